fifo_serial_tx: RTL and testbench
=================================

# fifo_serial_tx

Downstream consumer for the synchronous FIFO. It drains 5-bit words from the FIFO read port and transmits each one as an asynchronous serial frame on a single line: start bit, data LSB first, optional even parity, stop bit. The bit period is a fixed number of clocks set by a parameter. It sits between the FIFO and the board-level serial pin and owns all FIFO read strobes.

## Interface
- DATA_WIDTH, 5, word width; must match the FIFO data width.
- CLKS_PER_BIT, 4, clocks per serial bit; legal range 2..255.
- PARITY_EN, 0, when 1, an even-parity bit is inserted after the data bits.
- clock  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  DATA_WIDTH  FIFO read data; valid on the cycle after fifo_ren is asserted.
- fifo_ren  out  1  FIFO read strobe; one-cycle pulse per word.
- enable  in  1  permits new frames to start; does not affect a frame in progress.
- txd  out  1  serial line, idle high.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on the last cycle of each stop bit.
- frame_count  out  8  count of completed frames; wraps 255 -> 0.

## Operation
- Reset state: IDLE, txd=1, fifo_ren=0, busy=0, done=0, frame_count=0, shift register=0, bit and clock counters=0.
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE -> FETCH when enable=1 and fifo_empty=0, both sampled in IDLE. Otherwise the block stays in IDLE.
- FETCH: fifo_ren=1 for exactly this one cycle, then the block moves to LOAD. fifo_ren is asserted in no other state.
- LOAD: the block captures fifo_dout into the shift register, computes parity as the XOR of the data bits, and moves to START.
- START: txd=0 for CLKS_PER_BIT cycles, then the block moves to DATA.
- DATA: txd = shift_reg[0]. Each bit is held CLKS_PER_BIT cycles, then the register shifts right. After DATA_WIDTH bits the block moves to PARITY if PARITY_EN=1, else to STOP.
- PARITY: txd = parity bit for CLKS_PER_BIT cycles, then the block moves to STOP.
- STOP: txd=1 for CLKS_PER_BIT cycles. done=1 and frame_count increments on the final cycle. The block then moves to IDLE.
- The clock counter runs 0..CLKS_PER_BIT-1 and reloads to 0 on every state or bit change.
- The bit counter is wide enough for DATA_WIDTH-1.
- enable dropping mid-frame: the current frame completes normally and no further FETCH occurs.
- fifo_empty is ignored outside IDLE. The block never reads the FIFO while it reports empty.
- Reset mid-frame: on the next edge all registers take their reset values. txd returns high, the partial frame is abandoned with no done pulse, and any word already read is discarded.
- txd, fifo_ren, busy and done are decoded from registered state only; the outputs have no combinational path from the inputs.

## Timing
- Defaults (W=5, C=4, no parity), with fifo_ren in cycle t:
  - LOAD at t+1.
  - txd falls at t+2; start bit t+2..t+5.
  - Data bit k occupies t+6+4k..t+9+4k.
  - Stop bit t+26..t+29; done and the frame_count increment at t+29.
  - IDLE at t+30.
- Frame on the line: (1 + W + PARITY_EN + 1) * C cycles, which is 28 by default and 32 with parity.
- Back-to-back words: the next fifo_ren comes at t+31, giving a period of 31 cycles by default.
- A word becoming available while in IDLE: fifo_ren follows one cycle after fifo_empty is sampled low.
- busy rises in the FETCH cycle and falls on the IDLE cycle.

## Test plan
- Reset: drive rst=1 for 2 cycles with FIFO non-empty and enable=1. Required: txd=1, fifo_ren=0, busy=0, done=0, frame_count=0 throughout reset.
- Single word 5'b10110 with defaults:
  - Exactly one fifo_ren pulse.
  - txd sequence, each bit 4 cycles: 0,0,1,1,0,1,1.
  - done at t+29; frame_count=1; back in IDLE at t+30.
- Three words queued (5'h03, 5'h1F, 5'h00): fifo_ren pulses at t, t+31 and t+62. The LSB-first data bits match each word, and frame_count=3 at the end.
- enable=0 with a non-empty FIFO for 50 cycles: no fifo_ren and txd stays 1. Dropping enable during a frame's DATA state still completes that frame with done, and no further FIFO reads follow.
- Reset mid-frame: assert rst during data bit 2. On the next edge txd=1 and busy=0; no done pulse; frame_count is unchanged. A re-run after reset transmits the next FIFO word correctly.
- PARITY_EN=1, word 5'b10110: parity bit=1 after bit 4, stop at t+30..t+33, done at t+33. Separately, 256 frames of 5'h00 wrap frame_count to 0.

Source files
------------

// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: pulls words from a FIFO and sends each as start, data LSB first, optional even parity, stop.
// Latency: fifo_ren -> start bit 2 cycles, frame (2+DATA_WIDTH+PARITY_EN)*CLKS_PER_BIT cycles; holds off reads while a frame is on the line.
module fifo_serial_tx #(
    parameter int DATA_WIDTH   = 5,
    parameter int CLKS_PER_BIT = 4,
    parameter bit PARITY_EN    = 1'b0
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_ren,
    input  logic                  enable,
    output logic                  txd,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            frame_count
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        LOAD   = 3'd2,
        START  = 3'd3,
        DATA   = 3'd4,
        PARITY = 3'd5,
        STOP   = 3'd6
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic [DATA_WIDTH-1:0]   shift_next;
    logic                    par_bit;
    logic [CNT_W-1:0]        clk_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic                    bit_end;

    assign shift_next = shift_reg >> 1;
    assign bit_end    = (clk_cnt == CNT_LAST);

    // Outputs are loaded on the same edge as the state they belong to, so they stay purely registered.
    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= IDLE;
            shift_reg   <= '0;
            par_bit     <= 1'b0;
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            txd         <= 1'b1;
            fifo_ren    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && !fifo_empty) begin
                        state    <= FETCH;
                        fifo_ren <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                FETCH: begin
                    state    <= LOAD;
                    fifo_ren <= 1'b0;
                end
                LOAD: begin
                    shift_reg <= fifo_dout;
                    par_bit   <= ^fifo_dout;
                    clk_cnt   <= '0;
                    txd       <= 1'b0;
                    state     <= START;
                end
                START: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        txd     <= shift_reg[0];
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt   <= '0;
                        shift_reg <= shift_next;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY_EN) begin
                                txd   <= par_bit;
                                state <= PARITY;
                            end else begin
                                txd   <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            txd     <= shift_next[0];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        txd     <= 1'b1;
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    // done must be high during the final stop cycle, so it is set one count early.
                    if (clk_cnt == CNT_PENULT) begin
                        done        <= 1'b1;
                        frame_count <= frame_count + 8'd1;
                    end
                    if (bit_end) begin
                        clk_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    clk_cnt  <= '0;
                    bit_cnt  <= '0;
                    txd      <= 1'b1;
                    fifo_ren <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: one default instance (a) and one parity instance (b), each fed by a small FIFO model.
`timescale 1ns/1ps
module tb_fifo_serial_tx;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst = 1'b1;
    logic       en_a = 1'b1, en_b = 1'b1;
    logic       empty_a, empty_b;
    logic [4:0] dout_a = '0, dout_b = '0;
    logic       ren_a, ren_b, txd_a, txd_b, busy_a, busy_b, done_a, done_b;
    logic [7:0] fc_a, fc_b;

    fifo_serial_tx dut_a (
        .clock(clock), .rst(rst), .fifo_empty(empty_a), .fifo_dout(dout_a), .fifo_ren(ren_a),
        .enable(en_a), .txd(txd_a), .busy(busy_a), .done(done_a), .frame_count(fc_a)
    );

    fifo_serial_tx #(.DATA_WIDTH(5), .CLKS_PER_BIT(4), .PARITY_EN(1'b1)) dut_b (
        .clock(clock), .rst(rst), .fifo_empty(empty_b), .fifo_dout(dout_b), .fifo_ren(ren_b),
        .enable(en_b), .txd(txd_b), .busy(busy_b), .done(done_b), .frame_count(fc_b)
    );

    // FIFO models: read data appears the cycle after the strobe.
    logic [4:0] mem_a [0:511];
    logic [4:0] mem_b [0:511];
    int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
    int ren_cnt_a = 0, ren_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0, bad_reads = 0, cyc = 0;
    assign empty_a = (wr_a == rd_a);
    assign empty_b = (wr_b == rd_b);

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (ren_a) begin
            dout_a    <= mem_a[rd_a & 511];
            rd_a      <= rd_a + 1;
            ren_cnt_a <= ren_cnt_a + 1;
        end
        if (ren_b) begin
            dout_b    <= mem_b[rd_b & 511];
            rd_b      <= rd_b + 1;
            ren_cnt_b <= ren_cnt_b + 1;
        end
        if ((ren_a && empty_a) || (ren_b && empty_b)) bad_reads <= bad_reads + 1;
        if (done_a) done_cnt_a <= done_cnt_a + 1;
        if (done_b) done_cnt_b <= done_cnt_b + 1;
    end

    logic sel = 1'b0;
    logic m_txd, m_ren, m_busy, m_done;
    assign m_txd  = sel ? txd_b  : txd_a;
    assign m_ren  = sel ? ren_b  : ren_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_done = sel ? done_b : done_a;

    int n_pass = 0, n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic adv(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push(input logic s, input logic [4:0] w);
        if (s) begin mem_b[wr_b & 511] = w; wr_b++; end
        else   begin mem_a[wr_a & 511] = w; wr_a++; end
    endtask

    // Returns at the falling edge inside the fifo_ren cycle, or flags a failure after 'limit' cycles.
    task automatic wait_ren(input string name, input int limit, output int t);
        bit ok = 1'b0;
        t = -1;
        for (int i = 0; i < limit && !ok; i++) begin
            @(negedge clock);
            if (m_ren === 1'b1) begin ok = 1'b1; t = cyc; end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL %s: no fifo_ren within %0d cycles, expected one", name, limit);
        end
    endtask

    // Called in the fifo_ren cycle t; returns in cycle t + 2 + 4*nbits (the IDLE cycle).
    task automatic check_frame(input string name, input logic [7:0] line, input int nbits, input bit drop_en);
        logic [3:0] tpat, dpat;
        check({name, " busy in fetch"}, 32'(m_busy), 32'd1);
        adv(1);
        check({name, " ren one cycle"}, 32'({m_ren, m_busy}), 32'b01);
        adv(1);
        for (int b = 0; b < nbits; b++) begin
            for (int k = 0; k < 4; k++) begin
                tpat[k] = m_txd;
                dpat[k] = m_done;
                if (drop_en && b == 3 && k == 0) begin
                    if (sel) en_b = 1'b0; else en_a = 1'b0;
                end
                adv(1);
            end
            check($sformatf("%s bit%0d txd", name, b), 32'(tpat), 32'({4{line[b]}}));
            check($sformatf("%s bit%0d done", name, b), 32'(dpat), (b == nbits - 1) ? 32'h8 : 32'h0);
        end
        check({name, " idle after stop"}, 32'({m_busy, m_done, m_txd}), 32'b001);
    endtask

    typedef struct {
        logic       s;
        logic [4:0] word;
        logic [7:0] line;   // line bits in transmit order, bit 0 = start bit
        int         nbits;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t0, r0, d0, fc255;
        vecs[0] = '{1'b0, 5'h15, 8'h6A, 7};
        vecs[1] = '{1'b0, 5'h0A, 8'h54, 7};
        vecs[2] = '{1'b0, 5'h1F, 8'h7E, 7};
        vecs[3] = '{1'b1, 5'h16, 8'hEC, 8};   // parity 1
        vecs[4] = '{1'b1, 5'h03, 8'h86, 8};   // parity 0
        vecs[5] = '{1'b1, 5'h07, 8'hCE, 8};   // parity 1

        // Reset held two cycles with a word waiting and enable high.
        push(1'b0, 5'h19);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check($sformatf("reset a cyc%0d", i), 32'({txd_a, ren_a, busy_a, done_a, fc_a}), 32'h800);
            check($sformatf("reset b cyc%0d", i), 32'({txd_b, ren_b, busy_b, done_b, fc_b}), 32'h800);
        end
        rst = 1'b0;

        // The queued word starts; abort it in data bit 2 (cycles t+14..t+17).
        sel = 1'b0;
        wait_ren("abort", 10, t);
        adv(15);
        check("abort pre txd", 32'(txd_a), 32'd0);  // bit 2 of 5'h19 is 0
        rst = 1'b1;
        adv(1);
        check("abort reset outputs", 32'({txd_a, busy_a, done_a, ren_a, fc_a}), 32'h800);
        rst = 1'b0;
        adv(20);
        check("abort no done", 32'(done_cnt_a), 32'd0);
        check("abort word discarded", 32'(wr_a - rd_a), 32'd0);
        check("abort count", 32'(fc_a), 32'd0);

        // Single word after reset.
        r0 = ren_cnt_a;
        push(1'b0, 5'b10110);
        wait_ren("single", 10, t);
        check_frame("single", 8'h6C, 7, 1'b0);
        check("single ren pulses", 32'(ren_cnt_a - r0), 32'd1);
        check("single count", 32'(fc_a), 32'd1);

        // Table: one word at a time on each instance.
        foreach (vecs[i]) begin
            sel = vecs[i].s;
            push(vecs[i].s, vecs[i].word);
            wait_ren($sformatf("vec%0d", i), 10, t);
            check_frame($sformatf("vec%0d", i), vecs[i].line, vecs[i].nbits, 1'b0);
        end
        check("table count a", 32'(fc_a), 32'd4);
        check("table count b", 32'(fc_b), 32'd3);

        // Three words queued: reads 31 cycles apart.
        sel = 1'b0;
        push(1'b0, 5'h03); push(1'b0, 5'h1F); push(1'b0, 5'h00);
        wait_ren("three w0", 10, t0);
        check_frame("three w0", 8'h46, 7, 1'b0);
        wait_ren("three w1", 10, t);
        check("three period 1", 32'(t - t0), 32'd31);
        check_frame("three w1", 8'h7E, 7, 1'b0);
        wait_ren("three w2", 10, t);
        check("three period 2", 32'(t - t0), 32'd62);
        check_frame("three w2", 8'h40, 7, 1'b0);
        check("three count", 32'(fc_a), 32'd7);

        // enable low with data waiting: no reads, line idle.
        en_a = 1'b0;
        r0 = ren_cnt_a;
        push(1'b0, 5'h19);
        d0 = 0;
        for (int i = 0; i < 50; i++) begin
            adv(1);
            if (txd_a !== 1'b1) d0++;
        end
        check("en0 no reads", 32'(ren_cnt_a - r0), 32'd0);
        check("en0 txd low cycles", 32'(d0), 32'd0);

        // Drop enable mid-frame: frame completes, nothing further is read.
        en_a = 1'b1;
        wait_ren("endrop", 10, t);
        push(1'b0, 5'h0C);
        check_frame("endrop", 8'h72, 7, 1'b1);
        adv(40);
        check("endrop reads", 32'(ren_cnt_a - r0), 32'd1);
        check("endrop word left", 32'(wr_a - rd_a), 32'd1);
        check("endrop count", 32'(fc_a), 32'd8);

        // Wrap: after reset, leftover word plus 255 zeros is 256 frames.
        rst = 1'b1;
        adv(1);
        rst = 1'b0;
        en_a = 1'b1;
        d0 = done_cnt_a;
        for (int i = 0; i < 255; i++) push(1'b0, 5'h00);
        fc255 = -1;
        for (int i = 0; i < 9000 && (done_cnt_a - d0) < 256; i++) begin
            adv(1);
            if ((done_cnt_a - d0) == 255 && fc255 < 0) fc255 = int'(fc_a);
        end
        adv(3);
        check("wrap at 255", 32'(fc255), 32'd255);
        check("wrap frames", 32'(done_cnt_a - d0), 32'd256);
        check("wrap count", 32'(fc_a), 32'd0);
        check("wrap idle", 32'({busy_a, txd_a}), 32'b01);
        check("no read while empty", 32'(bad_reads), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
